// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master arbiter (m0 icache refill, m1 dbus window) in front
// of a single synchronous SRAM controller port.
// Ports: clk, rst (sync, active-high); mN_address/wrdata/rd/wr/lock in,
// mN_rddata/stall out; s_address/wrdata/rd/wr out, s_rddata/s_busy in.
// Build option: define SRAM_ARB_RR_EN for round-robin tie-break,
// otherwise master 1 wins every tie.
module sram_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] m0_address,
  input  logic [31:0] m0_wrdata,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic        m0_lock,
  output logic [31:0] m0_rddata,
  output logic        m0_stall,
  input  logic [23:0] m1_address,
  input  logic [31:0] m1_wrdata,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic        m1_lock,
  output logic [31:0] m1_rddata,
  output logic        m1_stall,
  output logic [23:0] s_address,
  output logic [31:0] s_wrdata,
  output logic        s_rd,
  output logic        s_wr,
  input  logic [31:0] s_rddata,
  input  logic        s_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GNT0 = 3'b010,
    GNT1 = 3'b100
  } state_t;

  localparam logic [7:0] LMAX = 8'(MAX_LOCK);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_oth_gnt;
  logic [7:0] r_lock_cnt;
  logic [7:0] w_lock_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       w_at_max;
  logic       w_req0;
  logic       w_req1;
  logic       w_win1;
  logic       w_g0;
  logic       w_g1;
  logic       w_done;
  logic       w_own_req;
  logic       w_own_lock;
  logic       w_oth_req;

  assign w_req0 = m0_rd | m0_wr;
  assign w_req1 = m1_rd | m1_wr;
  assign w_g0   = (r_state == GNT0);
  assign w_g1   = (r_state == GNT1);
  assign w_done = (s_rd | s_wr) & ~s_busy;

  assign m0_rddata = s_rddata;
  assign m1_rddata = s_rddata;

`ifdef SRAM_ARB_RR_EN
  logic r_last;
  logic w_enter;

  // On a tie, grant the master that did not win the previous grant.
  assign w_win1  = w_req1 & (~w_req0 | ~r_last);
  assign w_enter = (w_state_nxt != IDLE) && (w_state_nxt != r_state);

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= 1'b0;
    else if (w_enter)
      r_last <= (w_state_nxt == GNT1);
  end
`else
  assign w_win1 = w_req1;
`endif

  // Saturating increment; reaching LMAX marks the last allowed locked
  // completion before the waiting master is let in.
  assign w_cnt_inc = (r_lock_cnt >= LMAX) ? LMAX : r_lock_cnt + 8'd1;
  assign w_at_max  = (w_cnt_inc == LMAX);

  always_comb begin
    s_address = '0;
    s_wrdata  = '0;
    s_rd      = 1'b0;
    s_wr      = 1'b0;
    m0_stall  = w_req0;
    m1_stall  = w_req1;
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    w_oth_req  = 1'b0;
    w_oth_gnt  = IDLE;
    unique case (1'b1)
      w_g0: begin
        s_address  = m0_address;
        s_wrdata   = m0_wrdata;
        s_wr       = m0_wr;
        s_rd       = m0_rd & ~m0_wr;
        m0_stall   = w_req0 & s_busy;
        w_own_req  = w_req0;
        w_own_lock = m0_lock;
        w_oth_req  = w_req1;
        w_oth_gnt  = GNT1;
      end
      w_g1: begin
        s_address  = m1_address;
        s_wrdata   = m1_wrdata;
        s_wr       = m1_wr;
        s_rd       = m1_rd & ~m1_wr;
        m1_stall   = w_req1 & s_busy;
        w_own_req  = w_req1;
        w_own_lock = m1_lock;
        w_oth_req  = w_req0;
        w_oth_gnt  = GNT0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      IDLE: begin
        w_lock_cnt_nxt = '0;
        if (w_req0 | w_req1)
          w_state_nxt = w_win1 ? GNT1 : GNT0;
      end
      GNT0, GNT1: begin
        if (w_done) begin
          if (w_own_lock && !(w_at_max && w_oth_req)) begin
            w_lock_cnt_nxt = w_cnt_inc;
          end else begin
            w_lock_cnt_nxt = '0;
            w_state_nxt    = w_oth_req ? w_oth_gnt : IDLE;
          end
        end else if (!w_own_req && !w_own_lock) begin
          w_lock_cnt_nxt = '0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_lock_cnt_nxt = '0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

endmodule
